// File: rtl/ternary_weight_serializer_pkg.sv
// Shared constants, FSM state encoding and the ternary-to-pair encoder used by
// the serializer datapath and by its reference model.
package ternary_weight_serializer_pkg;

   localparam logic [1:0] W_POS     = 2'b01;
   localparam logic [1:0] W_NEG     = 2'b11;
   localparam logic [1:0] W_ZERO    = 2'b00;
   localparam logic [1:0] W_ILLEGAL = 2'b10;

   localparam int ZERO_BIT = 0;
   localparam int SIGN_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // The illegal code is folded into zero so the array never sees a bogus sign.
   function automatic logic [1:0] encode_pair(input logic [1:0] w);
      logic [1:0] pair;
      logic       zero;
      zero           = (w == W_ZERO) || (w == W_ILLEGAL);
      pair           = '0;
      pair[ZERO_BIT] = zero;
      pair[SIGN_BIT] = w[1] & ~zero;
      return pair;
   endfunction

endpackage

// File: rtl/ternary_pair_encode.sv
// One signed ternary weight -> the synapse array's {sign, zero} bit pair,
// plus a flag for the unused code.
module ternary_pair_encode
   import ternary_weight_serializer_pkg::*;
(
   input  logic [1:0] w,
   output logic [1:0] pair,
   output logic       illegal
);

   assign pair    = encode_pair(w);
   assign illegal = !(w inside {W_POS, W_NEG, W_ZERO});

endmodule

// File: rtl/ternary_weight_serializer.sv
// Serial transmit end of the ternary weight link: encodes a vector of N_SYN
// weights and shifts it MSB-first into the synapse array's weight register.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no frame on the wire; load on accept or pending vector
//   ST_SHIFT | ser_out carries frame bit bit_cnt (0 .. 2*N_SYN-1)
//   ST_GAP   | inter-frame idle for GAP cycles, then acts like ST_IDLE
module ternary_weight_serializer
   import ternary_weight_serializer_pkg::*;
#(
   parameter int N_SYN = 4,
   parameter int GAP   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*N_SYN-1:0] in_weights,
   output logic               ser_out,
   output logic               frame_active,
   output logic               load_strobe,
   output logic               busy,
   output logic               err_illegal,
   input  logic               err_clr
);

   localparam int FW = 2 * N_SYN;
   localparam int CW = (FW > 1) ? $clog2(FW) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);
   localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   state_t          state, state_nx;
   logic [FW-1:0]   enc_word, pend_word, next_word, shreg;
   logic [N_SYN-1:0] illegal_vec;
   logic [CW-1:0]   bit_cnt;
   logic [GW-1:0]   gap_cnt;
   logic            pending_full, strobe_q, ready_q;
   logic            accept, have_next, any_illegal;
   logic            load_shreg, shift_en, frame_end, gap_start, gap_dec;

   for (genvar i = 0; i < N_SYN; i++) begin : g_enc
      ternary_pair_encode u_enc (
         .w       (in_weights[2*i +: 2]),
         .pair    (enc_word[2*i +: 2]),
         .illegal (illegal_vec[i])
      );
   end

   assign any_illegal = |illegal_vec;
   assign accept      = in_valid & in_ready;
   assign have_next   = pending_full | accept;
   // A held vector always predates anything offered this cycle.
   assign next_word   = pending_full ? pend_word : enc_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      load_shreg = 1'b0;
      shift_en   = 1'b0;
      frame_end  = 1'b0;
      gap_start  = 1'b0;
      gap_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (have_next) begin
               load_shreg = 1'b1;
               state_nx   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
               frame_end = 1'b1;
               if (GAP > 0) begin
                  gap_start = 1'b1;
                  state_nx  = ST_GAP;
               end else if (have_next) begin
                  load_shreg = 1'b1;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt != '0) begin
               gap_dec = 1'b1;
            end else if (have_next) begin
               load_shreg = 1'b1;
               state_nx   = ST_SHIFT;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg        <= '0;
         bit_cnt      <= '0;
         gap_cnt      <= '0;
         pend_word    <= '0;
         pending_full <= 1'b0;
         strobe_q     <= 1'b0;
         ready_q      <= 1'b0;
         err_illegal  <= 1'b0;
      end else begin
         ready_q  <= 1'b1;
         strobe_q <= frame_end;

         if (load_shreg)    shreg <= next_word;
         else if (shift_en) shreg <= {shreg[FW-2:0], 1'b0};

         if (load_shreg || frame_end) bit_cnt <= '0;
         else if (shift_en)           bit_cnt <= bit_cnt + CW'(1);

         if (gap_start)    gap_cnt <= GAP_LAST;
         else if (gap_dec) gap_cnt <= gap_cnt - GW'(1);

         if (accept && !load_shreg) begin
            pend_word    <= enc_word;
            pending_full <= 1'b1;
         end else if (load_shreg && pending_full) begin
            pending_full <= 1'b0;
         end

         if (accept && any_illegal) err_illegal <= 1'b1;
         else if (err_clr)          err_illegal <= 1'b0;
      end
   end

   assign frame_active = (state == ST_SHIFT);
   assign ser_out      = frame_active & shreg[FW-1];
   assign load_strobe  = strobe_q;
   assign busy         = (state != ST_IDLE) | pending_full;
   assign in_ready     = ready_q & ~pending_full;

endmodule

// File: tb/tb_ternary_weight_serializer.sv
// Directed bench for the ternary weight serializer: a GAP=0 instance checked
// through a receiver-side scoreboard, and a GAP=2 instance checked per cycle.
module tb_ternary_weight_serializer;
   import ternary_weight_serializer_pkg::*;

   localparam int N     = 4;
   localparam int FB    = 2 * N;
   localparam int GAP_B = 2;

   logic          clk, rst;
   logic          a_in_valid, a_in_ready, a_ser_out, a_frame_active, a_load_strobe;
   logic          a_busy, a_err_illegal, a_err_clr;
   logic [FB-1:0] a_in_weights;
   logic          b_in_valid, b_in_ready, b_ser_out, b_frame_active, b_load_strobe;
   logic          b_busy, b_err_illegal, b_err_clr;
   logic [FB-1:0] b_in_weights;

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   logic [FB-1:0] exp_q[$];
   int            strobe_cyc[$];
   logic [FB-1:0] rx, last_rx;
   int            run, max_run;
   logic [FB-1:0] eb1, eb2;

   ternary_weight_serializer #(.N_SYN(N), .GAP(0)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_weights(a_in_weights), .ser_out(a_ser_out), .frame_active(a_frame_active),
      .load_strobe(a_load_strobe), .busy(a_busy), .err_illegal(a_err_illegal),
      .err_clr(a_err_clr)
   );

   ternary_weight_serializer #(.N_SYN(N), .GAP(GAP_B)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_weights(b_in_weights), .ser_out(b_ser_out), .frame_active(b_frame_active),
      .load_strobe(b_load_strobe), .busy(b_busy), .err_illegal(b_err_illegal),
      .err_clr(b_err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [FB-1:0] model_word(input logic [FB-1:0] w);
      logic [FB-1:0] e;
      e = '0;
      for (int i = 0; i < N; i++) e[2*i +: 2] = encode_pair(w[2*i +: 2]);
      return e;
   endfunction

   function automatic int weight_sum(input logic [FB-1:0] w);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
         if (w[2*i +: 2] == W_POS) s++;
         else if (w[2*i +: 2] == W_NEG) s--;
      end
      return s;
   endfunction

   // Value the array computes with all inputs at 1, decoded from received pairs.
   function automatic int array_sum(input logic [FB-1:0] r);
      int s;
      s = 0;
      for (int i = 0; i < N; i++)
         if (!r[2*i + ZERO_BIT]) s += r[2*i + SIGN_BIT] ? -1 : 1;
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Receiver model: shifts on every frame bit, scoreboard check on strobe.
   always @(negedge clk) begin
      if (rst) begin
         rx  = '0;
         run = 0;
      end else begin
         if (a_load_strobe) begin
            strobe_cyc.push_back(cyc);
            check("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("sb_rx_word", rx, exp_q.pop_front());
            last_rx = rx;
         end
         if (a_frame_active) begin
            rx = {rx[FB-2:0], a_ser_out};
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   end

   task automatic send_a(input logic [FB-1:0] w, output int waited);
      waited       = 0;
      a_in_valid   = 1'b1;
      a_in_weights = w;
      while (!a_in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("send_a_ready", a_in_ready, 1'b1);
      exp_q.push_back(model_word(w));
      @(negedge clk);
      a_in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [FB-1:0] w);
      int waited;
      waited       = 0;
      b_in_valid   = 1'b1;
      b_in_weights = w;
      while (!b_in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("send_b_ready", b_in_ready, 1'b1);
      @(negedge clk);
      b_in_valid = 1'b0;
   endtask

   task automatic wait_idle_a();
      int n;
      n = 0;
      while (a_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", a_busy, 1'b0);
   endtask

   task automatic check_b(input int c);
      int   s2;
      logic exp_fa, exp_st, exp_so;
      s2     = 1 + FB + GAP_B;
      exp_fa = (c >= 1 && c <= FB) || (c >= s2 && c < s2 + FB);
      exp_st = (c == 1 + FB) || (c == s2 + FB);
      exp_so = 1'b0;
      if (c >= 1 && c <= FB)          exp_so = eb1[FB - c];
      else if (c >= s2 && c < s2 + FB) exp_so = eb2[FB - 1 - (c - s2)];
      check($sformatf("gap_frame_active_c%0d", c), b_frame_active, exp_fa);
      check($sformatf("gap_strobe_c%0d", c), b_load_strobe, exp_st);
      check($sformatf("gap_ser_out_c%0d", c), b_ser_out, exp_so);
   endtask

   initial begin
      int            w_n, n_before;
      logic [FB-1:0] v1, e_lit, e_rst;

      rst = 1'b1;
      a_in_valid = 1'b0; a_in_weights = '0; a_err_clr = 1'b0;
      b_in_valid = 1'b0; b_in_weights = '0; b_err_clr = 1'b0;
      max_run = 0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", a_in_ready, 1'b0);
      check("rst_ser_out", a_ser_out, 1'b0);
      check("rst_frame_active", a_frame_active, 1'b0);
      check("rst_load_strobe", a_load_strobe, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_err", a_err_illegal, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", a_in_ready, 1'b1);

      // Single vector {+1,-1,0,+1}: exact bit timing and strobe on cycle 9
      v1    = 8'b01_00_11_01;
      e_lit = 8'b00011000;
      send_a(v1, w_n);
      for (int k = 0; k < FB; k++) begin
         check($sformatf("single_ser_out_b%0d", k), a_ser_out, e_lit[FB-1-k]);
         check($sformatf("single_active_b%0d", k), a_frame_active, 1'b1);
         check($sformatf("single_no_strobe_b%0d", k), a_load_strobe, 1'b0);
         @(negedge clk);
      end
      check("single_strobe", a_load_strobe, 1'b1);
      check("single_active_off", a_frame_active, 1'b0);
      @(negedge clk);
      check("single_strobe_once", a_load_strobe, 1'b0);
      check("single_idle", a_busy, 1'b0);
      check("single_rx_literal", last_rx, e_lit);
      check("single_array_sum", array_sum(last_rx), weight_sum(v1));
      check("single_no_err", a_err_illegal, 1'b0);

      // Three chained frames with backpressure on the third
      strobe_cyc.delete();
      max_run = 0;
      send_a(8'b01_11_01_11, w_n);
      send_a(8'hFF, w_n);
      check("b2b_second_no_wait", w_n, 0);
      send_a(8'b11_01_00_01, w_n);
      check("backpressure_wait_cycles", w_n, FB - 1);
      wait_idle_a();
      @(negedge clk);
      check("b2b_strobe_count", strobe_cyc.size(), 3);
      if (strobe_cyc.size() == 3) begin
         check("b2b_strobe_gap1", strobe_cyc[1] - strobe_cyc[0], FB);
         check("b2b_strobe_gap2", strobe_cyc[2] - strobe_cyc[1], FB);
      end
      check("b2b_active_run", max_run, 3 * FB);
      check("b2b_sb_drained", exp_q.size(), 0);

      // Illegal code, sticky error, set beats same-cycle clear, clear alone
      send_a(8'b00_00_00_10, w_n);
      check("illegal_err_set", a_err_illegal, 1'b1);
      wait_idle_a();
      check("illegal_err_sticky", a_err_illegal, 1'b1);
      a_err_clr = 1'b1;
      send_a(8'b10_00_01_00, w_n);
      a_err_clr = 1'b0;
      check("illegal_set_wins", a_err_illegal, 1'b1);
      wait_idle_a();
      a_err_clr = 1'b1;
      @(negedge clk);
      a_err_clr = 1'b0;
      check("illegal_err_cleared", a_err_illegal, 1'b0);

      // Reset mid-frame with a pending vector
      @(negedge clk);
      n_before = strobe_cyc.size();
      e_rst    = model_word(8'b11_00_11_11);
      send_a(8'b11_00_11_11, w_n);
      send_a(8'b01_01_01_01, w_n);
      @(negedge clk);
      @(negedge clk);
      check("midrst_pre_ser_out", a_ser_out, e_rst[FB-4]);
      check("midrst_pre_active", a_frame_active, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst_ser_out", a_ser_out, 1'b0);
      check("midrst_active", a_frame_active, 1'b0);
      check("midrst_strobe", a_load_strobe, 1'b0);
      check("midrst_busy", a_busy, 1'b0);
      check("midrst_in_ready", a_in_ready, 1'b0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_no_strobe", strobe_cyc.size(), n_before);
      check("midrst_pending_dropped", a_busy, 1'b0);
      send_a(8'b00_11_01_11, w_n);
      wait_idle_a();
      @(negedge clk);
      check("midrst_fresh_strobe", strobe_cyc.size(), n_before + 1);
      check("midrst_sb_drained", exp_q.size(), 0);

      // GAP=2 instance: two queued vectors, exact per-cycle pattern
      eb1 = model_word(8'b01_00_11_01);
      eb2 = model_word(8'hFF);
      send_b(8'b01_00_11_01);
      check_b(1);
      send_b(8'hFF);
      for (int c = 2; c <= 2 * FB + GAP_B + 4; c++) begin
         check_b(c);
         @(negedge clk);
      end
      check("gap_idle_end", b_busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
